ca90_item_memory_seq: RTL and testbench
=======================================

# ca90_item_memory_seq

Sequential, handshaked item memory that generates item HVs on demand by iterating the CA90 rule from a per-bank seed, instead of unrolling every bank. It also serves continuous item memory (CiM) levels from a separate seed. It sits between the encoder controller and the bind/bundle datapath. Its generation step count per cycle is parametrised, and it optionally reuses the last generated HV to shorten sequential accesses.

## Interface
- HVDimension, 512, HV width; multiple of SeedWidth
- NumTotIm, 1024, total item HVs; power of 2
- NumPerImBank, 128, items per seed bank; power of 2
- SeedWidth, 32, seed width
- StepsPerCycle, 4, CA90 steps applied per cycle; ≥1
- ImAddrWidth, $clog2(NumTotIm), derived
- NumImSets, NumTotIm/NumPerImBank, derived
- CimSelWidth, $clog2(HVDimension/2), derived

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- im_seed_hv_i  in  NumImSets×SeedWidth  per-bank seeds; sampled at request acceptance
- cim_seed_hv_i  in  SeedWidth  CiM seed; sampled at acceptance
- flush_i  in  1  invalidates cached HV
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_cim_i  in  1  1 = CiM request, 0 = iM request
- req_addr_i  in  ImAddrWidth  iM address; CiM level = req_addr_i[CimSelWidth-1:0]
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_hv_o  out  HVDimension  response HV
- busy_o  out  1  FSM not IDLE

## Operation
- Expand(s) = s replicated HVDimension/SeedWidth times.
- CA90 step: next[i] = cur[(i-1) mod D] XOR cur[(i+1) mod D], where D = HVDimension.
- Address fields: bank b = addr / NumPerImBank; index k = addr mod NumPerImBank.
- iM item(addr) = Expand(im_seed_hv_i[b]) stepped k times.
- CiM level l = Expand(cim_seed_hv_i) with bits [l-1:0] inverted; l = 0 is unmodified.
- FSM states: IDLE, STEP, HOLD.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, the request is accepted.
  - CiM request: the result is registered and the FSM goes to HOLD.
  - iM request: a start state and remaining step count r are selected (see Configuration).
  - If r = 0, go to HOLD; otherwise go to STEP.
- STEP:
  - Each cycle applies min(StepsPerCycle, r) steps and decrements r by the same amount.
  - When r reaches 0, go to HOLD.
- HOLD:
  - rsp_valid_o = 1 and rsp_hv_o is stable.
  - On rsp_ready_i, go to IDLE.
  - iM results update the cache: bank, index, HV, and the valid flag.
  - CiM results never touch the cache.
- req_ready_o = 0 in STEP and HOLD. No request is accepted in the same cycle as a response handshake.
- Seeds may change freely while IDLE. Seeds changing during STEP/HOLD do not affect the in-flight result.
- flush_i:
  - Clears the cache valid flag at any state.
  - flush_i during STEP/HOLD: the in-flight result is still delivered but is not stored in the cache.
  - flush_i in the same cycle as acceptance takes precedence, so the request uses the no-cache path.

## Timing
- Reset values:
  - req_ready_o = 1, rsp_valid_o = 0, rsp_hv_o = 0, busy_o = 0.
  - Cache valid = 0; FSM = IDLE.
- Reset asserted mid-operation aborts immediately. No response is produced.
- Latency counts from the acceptance cycle to the first cycle of rsp_valid_o:
  - CiM: 1 cycle.
  - iM: ceil(r/StepsPerCycle)+1 cycles.
- Minimum request spacing is 2 cycles: HOLD with an immediate rsp_ready_i, then IDLE.

## Configuration
- ITEM_MEMORY_CACHE_EN defined:
  - On acceptance, a cache hit is: cache valid, cached bank = b, and cached index ≤ k.
  - Hit: start from the cached HV with r = k − cached index.
  - Miss: start from Expand(seed) with r = k.
- ITEM_MEMORY_CACHE_EN undefined:
  - No cache registers exist; flush_i is ignored.
  - Every iM request starts from Expand(seed) with r = k.

## Test plan
Use HVDimension=64, SeedWidth=32, NumTotIm=16, NumPerImBank=8, StepsPerCycle=4.
- Reset release -> req_ready_o=1, rsp_valid_o=0, busy_o=0, rsp_hv_o=0.
- iM addr 0, seed[0]=32'h0000_0001 -> rsp_valid_o 1 cycle after accept; rsp_hv_o=64'h0000_0001_0000_0001.
- iM addr 5 (bank 0, k=5) -> rsp_valid_o 3 cycles after accept; HV matches a 5-step CA90 model.
- Back-to-back addr 5 then addr 7, same seed -> with ITEM_MEMORY_CACHE_EN, second latency 2 cycles; without it, 3 cycles. Both HVs match the model.
- CiM level 3, cim seed 32'hFFFF_0000 -> 1-cycle latency; rsp_hv_o=64'hFFFF_0000_FFFF_0007; a following iM addr 7 still hits the cache (2 cycles).
- rsp_ready_i held low 5 cycles during HOLD -> rsp_hv_o stable and req_ready_o=0. flush_i pulsed in HOLD, then addr 6 -> 3-cycle latency (cache miss).

Source files
------------

// File: rtl/ca90_item_memory_seq.sv
// Sequential CA90 item memory: generates iM item HVs by iterating CA90 from a per-bank seed and serves CiM levels.
// Define ITEM_MEMORY_CACHE_EN to reuse the last generated iM HV as a starting point for later indices in the same bank.
module ca90_item_memory_seq #(
   parameter int HVDimension   = 512,
   parameter int NumTotIm      = 1024,
   parameter int NumPerImBank  = 128,
   parameter int SeedWidth     = 32,
   parameter int StepsPerCycle = 4,
   parameter int ImAddrWidth   = $clog2(NumTotIm),
   parameter int NumImSets     = NumTotIm / NumPerImBank,
   parameter int CimSelWidth   = $clog2(HVDimension / 2)
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NumImSets-1:0][SeedWidth-1:0] im_seed_hv_i,
   input  logic [SeedWidth-1:0]                cim_seed_hv_i,
   input  logic                                flush_i,
   input  logic                                req_valid_i,
   output logic                                req_ready_o,
   input  logic                                req_cim_i,
   input  logic [ImAddrWidth-1:0]              req_addr_i,
   output logic                                rsp_valid_o,
   input  logic                                rsp_ready_i,
   output logic [HVDimension-1:0]              rsp_hv_o,
   output logic                                busy_o
);

   localparam int IdxWidth  = $clog2(NumPerImBank);
   localparam int BankWidth = (NumImSets > 1) ? $clog2(NumImSets) : 1;
   localparam int Reps      = HVDimension / SeedWidth;

   typedef enum logic [1:0] {IDLE, STEP, HOLD} state_t;

   // Each bit becomes the XOR of its two ring neighbours.
   function automatic logic [HVDimension-1:0] ca90_step(input logic [HVDimension-1:0] cur);
      return {cur[HVDimension-2:0], cur[HVDimension-1]} ^ {cur[0], cur[HVDimension-1:1]};
   endfunction

   state_t                 state_q, state_d;
   logic [HVDimension-1:0] hv_q, step_hv, seed_hv, cim_hv, cim_mask, start_hv;
   logic [IdxWidth-1:0]    rem_q, rem_next, start_rem, req_idx;
   logic [BankWidth-1:0]   req_bank;
   logic [CimSelWidth-1:0] cim_level;
   logic                   accept;
   int                     steps_now;

   assign accept    = req_valid_i & (state_q == IDLE);
   assign req_bank  = BankWidth'(req_addr_i >> IdxWidth);
   assign req_idx   = req_addr_i[IdxWidth-1:0];
   assign seed_hv   = {Reps{im_seed_hv_i[req_bank]}};
   assign cim_level = CimSelWidth'(req_addr_i);
   assign cim_mask  = (HVDimension'(1) << cim_level) - HVDimension'(1);
   assign cim_hv    = {Reps{cim_seed_hv_i}} ^ cim_mask;
   assign rsp_hv_o  = hv_q;

`ifdef ITEM_MEMORY_CACHE_EN
   logic                   cache_valid_q, flush_seen_q, pend_cim_q, hit;
   logic [BankWidth-1:0]   cache_bank_q, pend_bank_q;
   logic [IdxWidth-1:0]    cache_idx_q, pend_idx_q;
   logic [HVDimension-1:0] cache_hv_q;

   // A flush in the acceptance cycle forces the request onto the seed path.
   assign hit       = cache_valid_q & ~flush_i & (cache_bank_q == req_bank) & (cache_idx_q <= req_idx);
   assign start_hv  = hit ? cache_hv_q : seed_hv;
   assign start_rem = hit ? (req_idx - cache_idx_q) : req_idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cache_valid_q <= 1'b0;
         flush_seen_q  <= 1'b0;
         pend_cim_q    <= 1'b0;
         pend_bank_q   <= '0;
         pend_idx_q    <= '0;
         cache_bank_q  <= '0;
         cache_idx_q   <= '0;
         cache_hv_q    <= '0;
      end else begin
         if (accept) begin
            pend_cim_q   <= req_cim_i;
            pend_bank_q  <= req_bank;
            pend_idx_q   <= req_idx;
            flush_seen_q <= 1'b0;
         end else if (flush_i) begin
            flush_seen_q <= 1'b1;
         end
         if (flush_i) begin
            cache_valid_q <= 1'b0;
         end else if ((state_q == HOLD) && rsp_ready_i && !pend_cim_q && !flush_seen_q) begin
            cache_valid_q <= 1'b1;
            cache_bank_q  <= pend_bank_q;
            cache_idx_q   <= pend_idx_q;
            cache_hv_q    <= hv_q;
         end
      end
   end
`else
   logic unused_flush;

   assign unused_flush = flush_i;
   assign start_hv     = seed_hv;
   assign start_rem    = req_idx;
`endif

   always_comb begin
      step_hv = hv_q;
      for (int s = 0; s < StepsPerCycle; s++) begin
         if (s < int'(rem_q)) step_hv = ca90_step(step_hv);
      end
   end

   assign steps_now = (int'(rem_q) < StepsPerCycle) ? int'(rem_q) : StepsPerCycle;
   assign rem_next  = IdxWidth'(int'(rem_q) - steps_now);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      busy_o      = 1'b1;
      unique case (state_q)
         IDLE: begin
            req_ready_o = 1'b1;
            busy_o      = 1'b0;
            if (req_valid_i) state_d = (req_cim_i || (start_rem == '0)) ? HOLD : STEP;
         end
         STEP: if (int'(rem_q) <= StepsPerCycle) state_d = HOLD;
         HOLD: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Seeds are captured only at acceptance, so later seed changes cannot disturb an in-flight result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hv_q  <= '0;
         rem_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  if (req_cim_i) begin
                     hv_q <= cim_hv;
                  end else begin
                     hv_q  <= start_hv;
                     rem_q <= start_rem;
                  end
               end
            end
            STEP: begin
               hv_q  <= step_hv;
               rem_q <= rem_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ca90_item_memory_seq.sv
// Directed plus short random bench for ca90_item_memory_seq; latency expectations follow ITEM_MEMORY_CACHE_EN.
module tb_ca90_item_memory_seq;

   localparam int D   = 64;
   localparam int SW  = 32;
   localparam int NT  = 16;
   localparam int NPB = 8;
   localparam int SPC = 4;
   localparam int AW  = 4;
   localparam int NS  = 2;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NS-1:0][SW-1:0]  im_seed = '0;
   logic [SW-1:0]          cim_seed = '0;
   logic                   flush = 1'b0;
   logic                   req_valid = 1'b0;
   logic                   req_ready;
   logic                   req_cim = 1'b0;
   logic [AW-1:0]          req_addr = '0;
   logic                   rsp_valid;
   logic                   rsp_ready = 1'b0;
   logic [D-1:0]           rsp_hv;
   logic                   busy;

   int checks = 0;
   int fails  = 0;

   logic [D-1:0] exp_hv_q[$];
   int           exp_lat_q[$];

   bit m_valid = 1'b0;
   int m_bank  = 0;
   int m_idx   = 0;
   bit p_cim   = 1'b0;
   int p_bank  = 0;
   int p_idx   = 0;

   always #5 clk = ~clk;

   ca90_item_memory_seq #(
      .HVDimension(D), .NumTotIm(NT), .NumPerImBank(NPB), .SeedWidth(SW), .StepsPerCycle(SPC)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .im_seed_hv_i(im_seed), .cim_seed_hv_i(cim_seed),
      .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(req_ready), .req_cim_i(req_cim),
      .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_hv_o(rsp_hv), .busy_o(busy)
   );

   function automatic logic [D-1:0] ca90_model(input logic [D-1:0] c);
      logic [D-1:0] n;
      for (int i = 0; i < D; i++) n[i] = c[(i + D - 1) % D] ^ c[(i + 1) % D];
      return n;
   endfunction

   function automatic logic [D-1:0] item_model(input logic [SW-1:0] seed, input int k);
      logic [D-1:0] h;
      h = {seed, seed};
      for (int i = 0; i < k; i++) h = ca90_model(h);
      return h;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input bit cim, input logic [AW-1:0] addr, input bit flush_acc, input bit scramble);
      logic [D-1:0] hv;
      int b, k, r, lat;
      if (cim) begin
         hv = {cim_seed, cim_seed};
         for (int i = 0; i < int'(addr); i++) hv[i] = ~hv[i];
         lat = 1;
      end else begin
         b  = int'(addr) / NPB;
         k  = int'(addr) % NPB;
         hv = item_model(im_seed[b], k);
         r  = k;
`ifdef ITEM_MEMORY_CACHE_EN
         if (m_valid && !flush_acc && m_bank == b && m_idx <= k) r = k - m_idx;
`endif
         lat    = (r == 0) ? 1 : (r + SPC - 1) / SPC + 1;
         p_bank = b;
         p_idx  = k;
      end
      p_cim = cim;
      if (flush_acc) m_valid = 1'b0;
      exp_hv_q.push_back(hv);
      exp_lat_q.push_back(lat);
      @(negedge clk);
      check("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_cim   = cim;
      req_addr  = addr;
      flush     = flush_acc;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      flush     = 1'b0;
      if (scramble) begin
         im_seed  = {$urandom, $urandom};
         cim_seed = $urandom;
      end
   endtask

   task automatic check_output(input int hold, input bit flush_in_hold);
      logic [D-1:0] ehv;
      int elat, lat;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      ehv  = exp_hv_q.pop_front();
      elat = exp_lat_q.pop_front();
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("latency", 64'(lat), 64'(elat));
      check("rsp_hv", rsp_hv, ehv);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         flush = flush_in_hold && (i == 1);
         @(negedge clk);
         check("hold_hv", rsp_hv, ehv);
         check("hold_req_ready", 64'(req_ready), 64'd0);
         check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      flush     = 1'b0;
      if (flush_in_hold && hold >= 3) m_valid = 1'b0;
      else if (!p_cim) begin
         m_valid = 1'b1;
         m_bank  = p_bank;
         m_idx   = p_idx;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d fails=%0d", checks, fails);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", 64'(req_ready), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_rsp_hv", rsp_hv, 64'd0);

      im_seed[0] = 32'h0000_0001;
      im_seed[1] = 32'hA5A5_3C3C;
      cim_seed   = 32'hFFFF_0000;
      apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0);
      check_output(0, 1'b0);
      check("addr0_const", dut.hv_q, 64'h0000_0001_0000_0001);

      apply_stimulus(1'b0, 4'd5, 1'b0, 1'b0);
      check_output(0, 1'b0);
      apply_stimulus(1'b0, 4'd7, 1'b0, 1'b0);
      check_output(0, 1'b0);
      apply_stimulus(1'b0, 4'd5, 1'b0, 1'b0);
      check_output(0, 1'b0);

      apply_stimulus(1'b1, 4'd3, 1'b0, 1'b0);
      check_output(0, 1'b0);
      check("cim3_const", rsp_hv, 64'hFFFF_0000_FFFF_0007);
      apply_stimulus(1'b0, 4'd7, 1'b0, 1'b0);
      check_output(0, 1'b0);

      apply_stimulus(1'b0, 4'd12, 1'b0, 1'b0);
      check_output(0, 1'b0);
      apply_stimulus(1'b0, 4'd11, 1'b0, 1'b1);
      check_output(0, 1'b0);

      im_seed[0] = 32'h0000_0001;
      apply_stimulus(1'b0, 4'd3, 1'b0, 1'b0);
      check_output(5, 1'b1);
      apply_stimulus(1'b0, 4'd6, 1'b0, 1'b0);
      check_output(0, 1'b0);
      apply_stimulus(1'b0, 4'd7, 1'b1, 1'b0);
      check_output(0, 1'b0);

      $display("[TB] reset during generation");
      @(negedge clk);
      req_valid = 1'b1;
      req_cim   = 1'b0;
      req_addr  = 4'd15;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("midop_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("midop_rst_valid", 64'(rsp_valid), 64'd0);
      check("midop_rst_busy", 64'(busy), 64'd0);
      check("midop_rst_ready", 64'(req_ready), 64'd1);
      check("midop_rst_hv", rsp_hv, 64'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      m_valid = 1'b0;
      apply_stimulus(1'b0, 4'd1, 1'b0, 1'b0);
      check_output(0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         if (n % 3 == 0) begin
            im_seed  = {$urandom, $urandom};
            cim_seed = $urandom;
         end
         apply_stimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
         check_output($urandom_range(0, 2), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
